// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: func3 codes, FSM states, byte-enable seeds.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } func3_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Illegal width code or an address not aligned to the access width.
  function automatic logic access_fault(input logic store, input logic [2:0] func3,
                                        input logic [1:0] off);
    logic illegal;
    logic misaligned;
    illegal    = store ? (func3 >= 3'b011) : ((func3 == 3'b011) || (func3[2:1] == 2'b11));
    misaligned = ((func3[1:0] == 2'b01) && off[0]) || ((func3 == F3_W) && (off != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = word[{off[1], 4'b0000} +: 16];
    data   = word;
    case (func3)
      F3_B:    data = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_H:    data = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_BU:   data = {{(XLEN-8){1'b0}}, lane_b};
      F3_HU:   data = {{(XLEN-16){1'b0}}, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// One-at-a-time load/store sequencer: load 3 cycles, store 2, fault 1 from accept to response.
// req_ready only in IDLE; the response is a single pulse with no backpressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_func3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic [2:0]      mem_func3,
  output logic            mem_we,
  output logic            mem_re,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state, state_nxt;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, ext_data, wdata_in;
  logic [2:0]      func3_q;
  logic [3:0]      be_q, be_in;
  logic            store_q, fault_q, accept, fault_in;

  assign accept   = req_valid && req_ready;
  assign fault_in = access_fault(req_store, req_func3, req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = fault_in ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = store_q ? S_RESP : S_WAIT;
      S_WAIT:  state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE:  req_ready = 1'b1;
      S_ISSUE: begin
        mem_re = !store_q;
        mem_we = store_q;
      end
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Narrow stores are replicated across lanes so memory only needs the byte enables.
  always_comb begin
    be_in    = BE_WORD;
    wdata_in = req_wdata;
    case (req_func3)
      F3_B: begin
        be_in    = BE_BYTE << req_addr[1:0];
        wdata_in = {(XLEN/8){req_wdata[7:0]}};
      end
      F3_H: begin
        be_in    = BE_HALF << {req_addr[1], 1'b0};
        wdata_in = {(XLEN/16){req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .func3 (func3_q),
    .off   (addr_q[1:0]),
    .word  (mem_rdata),
    .data  (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      func3_q <= '0;
      be_q    <= '0;
      store_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      func3_q <= req_func3;
      store_q <= req_store;
      fault_q <= fault_in;
      rdata_q <= '0;
      be_q    <= (req_store && !fault_in) ? be_in : 4'b0000;
      wdata_q <= (req_store && !fault_in) ? wdata_in : '0;
    end else if (state == S_WAIT) begin
      rdata_q <= ext_data;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_func3  = func3_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a registered-read memory model plus response/strobe monitors.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_func3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault, mem_we, mem_re;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  mem_func3;
  logic [3:0]  mem_be;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_func3(mem_func3), .mem_we(mem_we), .mem_re(mem_re),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0, cyc = 0;
  int          re_cnt = 0, we_cnt = 0, resp_cnt = 0;
  logic [31:0] mem_word = '0, re_addr = '0, we_wdata = '0;
  logic [3:0]  we_be = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_re) mem_rdata <= mem_word;

  always @(negedge clk) begin
    exp_t e;
    if (mem_re) begin re_cnt++; re_addr = mem_addr; end
    if (mem_we) begin we_cnt++; we_be = mem_be; we_wdata = mem_wdata; end
    if (resp_valid) begin
      resp_cnt++;
      if (sb.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
        chk("resp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ef,
                       input int lat);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", 0, 1);
    req_valid = 1'b1; req_store = st; req_func3 = f3; req_addr = a; req_wdata = wd;
    sb.push_back('{er, ef, lat, cyc});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int re0, we0, r0, acc_n, rdy_n, last_acc;

    #2;
    chk("rst_mem_re", {31'd0, mem_re}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 1);

    // Loads: byte/half lanes with sign and zero extension.
    mem_word = 32'h80C3_7F01;
    re0 = re_cnt;
    issue(0, 3'b000, 32'h0000_0101, '0, 32'h0000_007F, 0, 3);
    drain();
    chk("lb_addr", re_addr, 32'h0000_0101);
    issue(0, 3'b000, 32'h0000_0103, '0, 32'hFFFF_FF80, 0, 3);
    drain();
    chk("lb_re_pulses", re_cnt - re0, 2);
    mem_word = 32'h8001_1234;
    issue(0, 3'b101, 32'h0000_0202, '0, 32'h0000_8001, 0, 3);
    issue(0, 3'b001, 32'h0000_0202, '0, 32'hFFFF_8001, 0, 3);
    issue(0, 3'b001, 32'h0000_0200, '0, 32'h0000_1234, 0, 3);
    issue(0, 3'b100, 32'h0000_0203, '0, 32'h0000_0080, 0, 3);
    issue(0, 3'b010, 32'h0000_0200, '0, 32'h8001_1234, 0, 3);
    drain();

    // Stores: lane replication and byte enables.
    we0 = we_cnt;
    issue(1, 3'b000, 32'h0000_0303, 32'h1234_56AB, 32'h0, 0, 2);
    drain();
    chk("sb_we_pulses", we_cnt - we0, 1);
    chk("sb_be", {28'd0, we_be}, 32'h8);
    chk("sb_wdata", we_wdata, 32'hABAB_ABAB);
    issue(1, 3'b001, 32'h0000_0302, 32'hFFFF_1234, 32'h0, 0, 2);
    drain();
    chk("sh_be", {28'd0, we_be}, 32'hC);
    chk("sh_wdata", we_wdata, 32'h1234_1234);
    issue(1, 3'b001, 32'h0000_0300, 32'h0000_5678, 32'h0, 0, 2);
    drain();
    chk("sh0_be", {28'd0, we_be}, 32'h3);
    issue(1, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 0, 2);
    drain();
    chk("sw_be", {28'd0, we_be}, 32'hF);
    chk("sw_wdata", we_wdata, 32'hDEAD_BEEF);
    chk("st_we_pulses", we_cnt - we0, 4);

    // Faults: no memory strobes, zero data, one-cycle response.
    re0 = re_cnt; we0 = we_cnt;
    issue(0, 3'b010, 32'h0000_0302, '0, 32'h0, 1, 1);
    issue(1, 3'b100, 32'h0000_0300, 32'hFFFF_FFFF, 32'h0, 1, 1);
    issue(0, 3'b001, 32'h0000_0301, '0, 32'h0, 1, 1);
    issue(0, 3'b110, 32'h0000_0300, '0, 32'h0, 1, 1);
    drain();
    chk("fault_no_re", re_cnt - re0, 0);
    chk("fault_no_we", we_cnt - we0, 0);

    // Back-to-back loads with req_valid held high.
    mem_word = 32'hCAFE_F00D;
    re0 = re_cnt; r0 = resp_cnt; acc_n = 0; rdy_n = 0; last_acc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_func3 = 3'b010; req_addr = 32'h0000_0400;
    for (int i = 0; i < 10; i++) begin
      if (req_ready) begin
        rdy_n++;
        if (last_acc >= 0) chk("accept_gap", cyc - last_acc, 4);
        last_acc = cyc;
        acc_n++;
        sb.push_back('{32'hCAFE_F00D, 1'b0, 3, cyc});
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
    chk("busy_accepts", acc_n, 3);
    chk("busy_ready_only_at_accept", rdy_n, acc_n);
    chk("busy_resps", resp_cnt - r0, acc_n);
    chk("busy_re_pulses", re_cnt - re0, acc_n);

    // Reset while waiting for read data aborts the access.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_func3 = 3'b010; req_addr = 32'h0000_0500;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_addr", mem_addr, 32'h0000_0500);
    r0 = resp_cnt;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_re", {31'd0, mem_re}, 0);
    chk("arst_mem_we", {31'd0, mem_we}, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_func3", {29'd0, mem_func3}, 0);
    chk("arst_mem_be", {28'd0, mem_be}, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_resp_valid", {31'd0, resp_valid}, 0);
    chk("arst_resp_rdata", resp_rdata, 0);
    chk("arst_resp_fault", {31'd0, resp_fault}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 1);
    chk("aborted_no_resp", resp_cnt - r0, 0);
    mem_word = 32'h0123_4567;
    issue(0, 3'b010, 32'h0000_0600, '0, 32'h0123_4567, 0, 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
